// File: rtl/calc_req_engine_if.sv
// rtl/calc_req_engine_if.sv - request/response bus of the calculator request engine
// Purpose: bundles the request push signals and the tagged response bus.
// Signals:
//   req_cmd_in/req_d1/req_d2/req_r1/req_tag_in/req_data_in : request fields
//   req_ready : queue can accept a request     req_ovf : sticky drop flag
//   out_data/out_resp/out_tag : one-cycle tagged response
// Modports: master = request driver, slave = engine.
interface calc_req_engine_if;
  logic [3:0]  req_cmd_in;
  logic [3:0]  req_d1;
  logic [3:0]  req_d2;
  logic [3:0]  req_r1;
  logic [1:0]  req_tag_in;
  logic [0:31] req_data_in;
  logic        req_ready;
  logic        req_ovf;
  logic [0:31] out_data;
  logic [1:0]  out_resp;
  logic [1:0]  out_tag;

  modport master (
    output req_cmd_in, req_d1, req_d2, req_r1, req_tag_in, req_data_in,
    input  req_ready, req_ovf, out_data, out_resp, out_tag
  );

  modport slave (
    input  req_cmd_in, req_d1, req_d2, req_r1, req_tag_in, req_data_in,
    output req_ready, req_ovf, out_data, out_resp, out_tag
  );
endinterface

// File: rtl/calc_req_engine.sv
// rtl/calc_req_engine.sv - in-order calculator request engine with request FIFO and 16x32 register file
// Purpose: queues requests, executes them one at a time against the register
//   file and returns one tagged response per accepted request.
// Ports:
//   clk : clock, rising edge      rst : synchronous reset, active-high
//   bus : calc_req_engine_if.slave (request fields in, ready/ovf/response out)
module calc_req_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_LAT    = 1,
  parameter int SHIFT_LAT  = 2
) (
  input logic              clk,
  input logic              rst,
  calc_req_engine_if.slave bus
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int MAXLAT = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  localparam logic [3:0] CMD_ADD   = 4'd1;
  localparam logic [3:0] CMD_SUB   = 4'd2;
  localparam logic [3:0] CMD_SHL   = 4'd5;
  localparam logic [3:0] CMD_SHR   = 4'd6;
  localparam logic [3:0] CMD_STORE = 4'd9;
  localparam logic [3:0] CMD_FETCH = 4'd10;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  r1;
    logic [1:0]  tag;
    logic [0:31] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t      state, next_state;
  req_t        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic        ovf;
  logic        push, pop;
  req_t        cur;
  logic [0:31] regs [16];
  logic [0:31] op_a, op_b;
  logic [CW-1:0] lat_cnt;
  logic        is_alu;

  logic [32:0] sum;
  logic [1:0]  res_resp;
  logic [0:31] res_data;
  logic        wb_en;
  logic [0:31] wb_data;

  // Ready comes from the registered count only, so a full queue refuses a
  // request even when a pop happens on the same edge.
  assign bus.req_ready = (count != FIFO_DEPTH[PW:0]);
  assign bus.req_ovf   = ovf;
  assign push = (bus.req_cmd_in != 4'd0) && bus.req_ready;
  assign pop  = ((state == IDLE) || (state == RESP)) && (count != '0);

  assign is_alu = (cur.cmd == CMD_ADD) || (cur.cmd == CMD_SUB) ||
                  (cur.cmd == CMD_SHL) || (cur.cmd == CMD_SHR);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{cmd: bus.req_cmd_in, d1: bus.req_d1, d2: bus.req_d2,
                            r1: bus.req_r1, tag: bus.req_tag_in, data: bus.req_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      state   <= IDLE;
      cur     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      lat_cnt <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((bus.req_cmd_in != 4'd0) && !bus.req_ready) ovf <= 1'b1;
      if (pop) cur <= fifo_mem[rd_ptr];
      if (state == READ) begin
        op_a <= regs[cur.d1];
        op_b <= regs[cur.d2];
        // Loaded with LAT-1 so EXEC lasts exactly LAT cycles.
        if ((cur.cmd == CMD_SHL) || (cur.cmd == CMD_SHR))
          lat_cnt <= CW'(SHIFT_LAT - 1);
        else
          lat_cnt <= CW'(ADD_LAT - 1);
      end
      if ((state == EXEC) && (lat_cnt != '0)) lat_cnt <= lat_cnt - 1'b1;
      // Writeback on the edge leaving RESP, ahead of the next READ.
      if ((state == RESP) && wb_en) regs[cur.r1] <= wb_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (count != '0) next_state = READ;
      READ: next_state = is_alu ? EXEC : RESP;
      EXEC: if (lat_cnt == '0) next_state = RESP;
      RESP: next_state = (count != '0) ? READ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result of the current request, valid once operands are latched.
  always_comb begin
    res_resp = 2'd3;
    res_data = '0;
    wb_en    = 1'b0;
    wb_data  = '0;
    sum      = {1'b0, op_a} + {1'b0, op_b};
    case (cur.cmd)
      CMD_ADD: begin
        if (sum[32]) res_resp = 2'd2;
        else begin
          res_resp = 2'd1;
          res_data = sum[31:0];
          wb_en    = 1'b1;
          wb_data  = sum[31:0];
        end
      end
      CMD_SUB: begin
        if (op_b > op_a) res_resp = 2'd2;
        else begin
          res_resp = 2'd1;
          res_data = op_a - op_b;
          wb_en    = 1'b1;
          wb_data  = op_a - op_b;
        end
      end
      CMD_SHL: begin
        res_resp = 2'd1;
        res_data = op_a << op_b[27:31];
        wb_en    = 1'b1;
        wb_data  = op_a << op_b[27:31];
      end
      CMD_SHR: begin
        res_resp = 2'd1;
        res_data = op_a >> op_b[27:31];
        wb_en    = 1'b1;
        wb_data  = op_a >> op_b[27:31];
      end
      CMD_STORE: begin
        res_resp = 2'd1;
        wb_en    = 1'b1;
        wb_data  = cur.data;
      end
      CMD_FETCH: begin
        res_resp = 2'd1;
        res_data = op_a;
      end
      default: res_resp = 2'd3;
    endcase
  end

  always_comb begin
    bus.out_resp = 2'd0;
    bus.out_data = '0;
    bus.out_tag  = 2'd0;
    if (state == RESP) begin
      bus.out_resp = res_resp;
      bus.out_data = res_data;
      bus.out_tag  = cur.tag;
    end
  end

endmodule

// File: tb/tb_calc_req_engine.sv
// tb/tb_calc_req_engine.sv - self-checking bench for calc_req_engine
module tb_calc_req_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_req_engine_if bus();

  calc_req_engine #(.FIFO_DEPTH(4), .ADD_LAT(1), .SHIFT_LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [1:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mreg[16];
  bit          model_ovf;
  int          tests, fails;
  int          cyc, start_cyc, last_cyc, resp_cnt;
  logic [1:0]  last_resp, last_tag;
  logic [31:0] last_data;
  logic        last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural model: requests take effect in acceptance order.
  function automatic void model_apply(input logic [3:0] cmd, input logic [3:0] d1,
      input logic [3:0] d2, input logic [3:0] r1, input logic [1:0] tag, input logic [31:0] data);
    exp_t e;
    longint unsigned a, b;
    a = mreg[d1];
    b = mreg[d2];
    e.tag = tag; e.resp = 2'd1; e.data = 32'd0;
    case (cmd)
      4'd1: if (a + b > 64'hFFFF_FFFF) e.resp = 2'd2;
            else begin e.data = 32'(a + b); mreg[r1] = e.data; end
      4'd2: if (b > a) e.resp = 2'd2;
            else begin e.data = 32'(a - b); mreg[r1] = e.data; end
      4'd5: begin e.data = 32'(a * (64'd1 << (b % 32))); mreg[r1] = e.data; end
      4'd6: begin e.data = 32'(a / (64'd1 << (b % 32))); mreg[r1] = e.data; end
      4'd9: mreg[r1] = data;
      4'd10: e.data = 32'(a);
      default: e.resp = 2'd3;
    endcase
    expq.push_back(e);
  endfunction

  function automatic void model_reset();
    expq.delete();
    for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
    model_ovf = 1'b0;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (bus.out_resp != 2'd0) begin
        resp_cnt++;
        last_resp = bus.out_resp; last_tag = bus.out_tag;
        last_data = bus.out_data; last_cyc = cyc;
        if (expq.size() == 0) chk("unexpected_resp", 32'(bus.out_resp), 32'd0);
        else begin
          e = expq.pop_front();
          chk("resp", 32'(bus.out_resp), 32'(e.resp));
          chk("tag", 32'(bus.out_tag), 32'(e.tag));
          chk("data", bus.out_data, e.data);
        end
      end else begin
        chk("idle_data", bus.out_data, 32'd0);
        chk("idle_tag", 32'(bus.out_tag), 32'd0);
      end
      chk("ovf", 32'(bus.req_ovf), 32'(model_ovf));
    end
  end

  task automatic drive(input logic [3:0] cmd, input logic [3:0] d1, input logic [3:0] d2,
      input logic [3:0] r1, input logic [1:0] tag, input logic [31:0] data);
    @(negedge clk);
    bus.req_cmd_in = cmd; bus.req_d1 = d1; bus.req_d2 = d2; bus.req_r1 = r1;
    bus.req_tag_in = tag; bus.req_data_in = data;
    start_cyc = cyc;
    last_rdy = bus.req_ready;
    @(posedge clk); #1;
    bus.req_cmd_in = 4'd0; bus.req_d1 = 4'd0; bus.req_d2 = 4'd0; bus.req_r1 = 4'd0;
    bus.req_tag_in = 2'd0; bus.req_data_in = 32'd0;
    if (cmd != 4'd0) begin
      if (last_rdy) model_apply(cmd, d1, d2, r1, tag, data);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain", 32'(expq.size()), 32'd0);
  endtask

  task automatic op(input logic [3:0] cmd, input logic [3:0] d1, input logic [3:0] d2,
      input logic [3:0] r1, input logic [1:0] tag, input logic [31:0] data);
    drive(cmd, d1, d2, r1, tag, data);
    wait_drain();
  endtask

  logic rdy_seen [6];
  int   rc0;
  localparam logic [5:0] RDY_EXP = 6'b011111;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; resp_cnt = 0;
    rst = 1'b1;
    bus.req_cmd_in = 4'd0; bus.req_d1 = 4'd0; bus.req_d2 = 4'd0; bus.req_r1 = 4'd0;
    bus.req_tag_in = 2'd0; bus.req_data_in = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp", 32'(bus.out_resp), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_ovf", 32'(bus.req_ovf), 32'd0);

    op(4'd9, 0, 0, 3, 2'd1, 32'h0000_0005);
    chk("store_lat", 32'(last_cyc - start_cyc), 32'd3);
    chk("store_resp", 32'(last_resp), 32'd1);
    chk("store_tag", 32'(last_tag), 32'd1);
    chk("store_data", last_data, 32'd0);

    op(4'd9, 0, 0, 4, 2'd0, 32'd7);
    op(4'd1, 3, 4, 6, 2'd2, 32'd0);
    chk("add_lat", 32'(last_cyc - start_cyc), 32'd4);
    chk("add_resp", 32'(last_resp), 32'd1);
    chk("add_data", last_data, 32'hC);
    chk("add_tag", 32'(last_tag), 32'd2);
    op(4'd10, 6, 0, 0, 2'd0, 32'd0);
    chk("fetch_data", last_data, 32'hC);
    chk("fetch_lat", 32'(last_cyc - start_cyc), 32'd3);

    op(4'd9, 0, 0, 1, 2'd0, 32'hFFFF_FFFF);
    op(4'd9, 0, 0, 2, 2'd0, 32'd1);
    op(4'd1, 1, 2, 3, 2'd1, 32'd0);
    chk("add_ovf_resp", 32'(last_resp), 32'd2);
    chk("add_ovf_data", last_data, 32'd0);
    op(4'd10, 3, 0, 0, 2'd0, 32'd0);
    chk("add_ovf_nowb", last_data, 32'd5);
    op(4'd2, 2, 1, 3, 2'd0, 32'd0);
    chk("sub_unf_resp", 32'(last_resp), 32'd2);
    op(4'd2, 1, 2, 9, 2'd0, 32'd0);
    chk("sub_data", last_data, 32'hFFFF_FFFE);

    op(4'd9, 0, 0, 1, 2'd0, 32'd1);
    op(4'd9, 0, 0, 2, 2'd0, 32'h21);
    op(4'd5, 1, 2, 7, 2'd0, 32'd0);
    chk("shl_lat", 32'(last_cyc - start_cyc), 32'd5);
    chk("shl_data", last_data, 32'd2);
    op(4'd6, 2, 1, 8, 2'd0, 32'd0);
    chk("shr_data", last_data, 32'h10);
    op(4'hF, 0, 0, 0, 2'd3, 32'd0);
    chk("inv_resp", 32'(last_resp), 32'd3);
    chk("inv_tag", 32'(last_tag), 32'd3);
    chk("inv_lat", 32'(last_cyc - start_cyc), 32'd3);

    // Six back-to-back shifts against a 4-deep queue: the sixth is dropped.
    rc0 = resp_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(4'd5, 2, 1, 4'(8 + i), 2'(i), 32'd0);
      rdy_seen[i] = last_rdy;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("burst_ready%0d", i), 32'(rdy_seen[i]), 32'(RDY_EXP[i]));
    wait_drain();
    chk("burst_ovf", 32'(bus.req_ovf), 32'd1);
    chk("burst_resp_count", 32'(resp_cnt - rc0), 32'd5);

    // Reset while an ADD sits in EXEC.
    drive(4'd1, 3, 4, 9, 2'd1, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_resp", 32'(bus.out_resp), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_ovf", 32'(bus.req_ovf), 32'd0);
    repeat (6) @(negedge clk);
    op(4'd10, 3, 0, 0, 2'd0, 32'd0);
    chk("mid_rst_r3", last_data, 32'd0);
    op(4'd10, 6, 0, 0, 2'd1, 32'd0);
    chk("mid_rst_r6", last_data, 32'd0);
    chk("mid_rst_tag", 32'(last_tag), 32'd1);

    chk("final_queue", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
